// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: gates mult/div/mthi/mtlo into the unit,
// tracks the unit's start/busy life cycle and stalls D on HI/LO hazards. Option: MD_PERF_CNT_EN.
module md_issue_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic        d_md_use,
    input  logic        m_exc,
    input  logic        md_busy,
    output logic [3:0]  md_op,
    output logic        stall_d,
    output logic        md_err,
    output logic [31:0] perf_cnt
);
    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          md_err_q, md_err_d;
    logic          live, is_md, is_wr, idle, issue, wr;

    // Gating on reset keeps the unit quiet while the controller is held in reset.
    assign live  = e_valid & ~m_exc & reset;
    assign is_md = (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
    assign is_wr = (e_md_op == 4'd7) || (e_md_op == 4'd8);
    assign idle  = (state_q == IDLE);
    assign issue = live & is_md & ~md_busy & idle;
    assign wr    = live & is_wr & ~md_busy & idle;

    assign md_op   = (issue | wr) ? e_md_op : 4'd0;
    assign stall_d = d_md_use & (issue | ~idle | md_busy);
    assign md_err  = md_err_q;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        md_err_d = md_err_q;
        // A unit op reaching E while a result is in flight means the D stall leaked.
        if (live & (is_md | is_wr) & (~idle | md_busy))
            md_err_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (md_busy) begin
                    state_d = BUSY;
                end else begin
                    state_d  = IDLE;
                    md_err_d = 1'b1;
                end
            end
            BUSY: begin
                if (!md_busy) begin
                    state_d = IDLE;
                end else if (tcnt_q == TMAX) begin
                    md_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            md_err_q <= md_err_d;
        end
    end

`ifdef MD_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d   = perf_q + {31'd0, stall_d};
    assign perf_cnt = perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= 32'd0;
        else        perf_q <= perf_d;
    end
`else
    assign perf_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: directed per-cycle vectors push expectations, a negedge
// monitor pops and compares. A small stub models the unit's busy window after a start.
module tb_md_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        e_valid = 1'b0;
    logic [3:0]  e_md_op = 4'd0;
    logic        d_md_use = 1'b0;
    logic        m_exc = 1'b0;
    logic        md_busy;
    logic [3:0]  md_op;
    logic        stall_d;
    logic        md_err;
    logic [31:0] perf_cnt;

    md_issue_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .d_md_use(d_md_use), .m_exc(m_exc), .md_busy(md_busy),
        .md_op(md_op), .stall_d(stall_d), .md_err(md_err), .perf_cnt(perf_cnt)
    );

    always #5 clk = ~clk;

`ifdef MD_PERF_CNT_EN
    localparam logic [31:0] PERF_T1 = 32'd7;
`else
    localparam logic [31:0] PERF_T1 = 32'd0;
`endif

    // Unit stub: busy for busy_len cycles after a start; it has no reset of its own.
    int busy_len = 5;
    int busy_left = 0;
    always @(posedge clk) begin
        if ((md_op >= 4'd1) && (md_op <= 4'd4) && (busy_len != 0)) busy_left <= busy_len;
        else if (busy_left != 0) busy_left <= busy_left - 1;
    end
    assign md_busy = (busy_left != 0);

    typedef struct packed {
        logic [31:0] id;
        logic [3:0]  op;
        logic        st;
        logic        er;
        logic        cp;
        logic [31:0] pf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (md_op !== e.op) begin
                n_bad++;
                $display("FAIL vec%0d md_op: got %0d want %0d", e.id, md_op, e.op);
            end
            n_cmp++;
            if (stall_d !== e.st) begin
                n_bad++;
                $display("FAIL vec%0d stall_d: got %0b want %0b", e.id, stall_d, e.st);
            end
            n_cmp++;
            if (md_err !== e.er) begin
                n_bad++;
                $display("FAIL vec%0d md_err: got %0b want %0b", e.id, md_err, e.er);
            end
            if (e.cp) begin
                n_cmp++;
                if (perf_cnt !== e.pf) begin
                    n_bad++;
                    $display("FAIL vec%0d perf_cnt: got %0d want %0d", e.id, perf_cnt, e.pf);
                end
            end
        end
    end

    task automatic cyc(input logic rs, input logic ev, input logic [3:0] op, input logic du,
                       input logic mx, input logic [3:0] xop, input logic xst, input logic xer,
                       input logic cp, input logic [31:0] xp);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs; e_valid = ev; e_md_op = op; d_md_use = du; m_exc = mx;
        e.id = 32'(vec); e.op = xop; e.st = xst; e.er = xer; e.cp = cp; e.pf = xp;
        sb.push_back(e);
        vec++;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state: live op is gated, no stall without busy, counters clear.
        cyc(0, 1, 4'd1, 1, 0, 4'd0, 0, 0, 1, 32'd0);
        cyc(1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 32'd0);

        // 1: mult with D mfhi, 5-cycle unit -> 7 stall cycles.
        busy_len = 5;
        cyc(1, 1, 4'd1, 1, 0, 4'd1, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, PERF_T1);
        quiet(2);

        // 2: div killed by m_exc; nothing starts, mflo not stalled.
        cyc(1, 1, 4'd2, 1, 1, 4'd0, 0, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0, 0);
        quiet(2);

        // 3: mtlo passes through without starting the FSM.
        cyc(1, 1, 4'd8, 1, 0, 4'd8, 0, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0, 0);
        // Op boundaries: mfhi and illegal never reach the unit, mthi does.
        cyc(1, 1, 4'd5, 0, 0, 4'd0, 0, 0, 0, 0);
        cyc(1, 1, 4'd12, 0, 0, 4'd0, 0, 0, 0, 0);
        cyc(1, 1, 4'd7, 0, 0, 4'd7, 0, 0, 0, 0);
        cyc(1, 1, 4'd0, 1, 0, 4'd0, 0, 0, 0, 0);

        // 4: unit busy 20 cycles -> timeout error, stall held until busy drops.
        busy_len = 20;
        cyc(1, 1, 4'd1, 1, 0, 4'd1, 1, 0, 0, 0);
        for (int i = 1; i <= 18; i++) cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        for (int i = 19; i <= 21; i++) cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, 0);
        cyc(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 32'd0);
        quiet(1);

        // 5: reset mid-BUSY while unit keeps running.
        busy_len = 5;
        cyc(1, 1, 4'd1, 1, 0, 4'd1, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(0, 1, 4'd1, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0, 0);
        quiet(1);

        // Unit never goes busy after a start: missed-start error.
        busy_len = 0;
        cyc(1, 1, 4'd3, 0, 0, 4'd3, 0, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, 0);
        cyc(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
